// File: rtl/uart_rx_fifo_if.sv
// Valid/ready character stream between the UART receiver, the receive FIFO
// and the register read path.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver, with
// level-trigger, character-timeout and sticky overrun interrupt sources.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LOG_DEPTH  = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  uart_rx_fifo_if.slave        in_if,
  uart_rx_fifo_if.master       out_if,
  output logic [LOG_DEPTH:0]   elements_o,
  output logic                 full_o,
  output logic                 empty_o,
  input  logic [LOG_DEPTH:0]   cfg_trig_lvl_i,
  output logic                 trig_o,
  input  logic [15:0]          cfg_timeout_i,
  output logic                 timeout_o,
  output logic                 overrun_o,
  input  logic                 overrun_clr_i
);

  localparam logic [LOG_DEPTH:0] FULL_COUNT = (LOG_DEPTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LOG_DEPTH-1:0]  wr_ptr;
  logic [LOG_DEPTH-1:0]  rd_ptr;
  logic [LOG_DEPTH:0]    count;
  logic [15:0]           idle_cnt;
  logic                  push;
  logic                  pop;

  assign full_o       = (count == FULL_COUNT);
  assign empty_o      = (count == '0);
  assign elements_o   = count;
  assign in_if.ready  = !full_o;
  assign out_if.valid = !empty_o;
  assign out_if.data  = mem[rd_ptr];

  assign push = in_if.valid && in_if.ready;
  assign pop  = out_if.valid && out_if.ready;

  assign trig_o    = (cfg_trig_lvl_i != '0) && (count >= cfg_trig_lvl_i);
  assign timeout_o = (cfg_timeout_i != 16'd0) && !empty_o && (idle_cnt >= cfg_timeout_i);

  // Storage is deliberately left unreset; a flush only discards the pointers.
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) begin
      mem[wr_ptr] <= in_if.data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Idle time since the last transfer; only meaningful while data is waiting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt <= '0;
    end else if (clr_i || push || pop || empty_o) begin
      idle_cnt <= '0;
    end else if (idle_cnt != 16'hFFFF) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overrun_o <= 1'b0;
    end else if (clr_i || overrun_clr_i) begin
      overrun_o <= 1'b0;
    end else if (in_if.valid && full_o) begin
      overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus queues expected characters,
// an independent monitor checks every character the FIFO hands out.
module tb_uart_rx_fifo;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int LD = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          clr_i = 1'b0;
  logic [LD:0]   elements_o;
  logic          full_o;
  logic          empty_o;
  logic [LD:0]   cfg_trig_lvl_i = '0;
  logic          trig_o;
  logic [15:0]   cfg_timeout_i = '0;
  logic          timeout_o;
  logic          overrun_o;
  logic          overrun_clr_i = 1'b0;

  uart_rx_fifo_if #(.DATA_WIDTH(DW)) in_if ();
  uart_rx_fifo_if #(.DATA_WIDTH(DW)) out_if ();

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .clr_i          (clr_i),
    .in_if          (in_if),
    .out_if         (out_if),
    .elements_o     (elements_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .cfg_trig_lvl_i (cfg_trig_lvl_i),
    .trig_o         (trig_o),
    .cfg_timeout_i  (cfg_timeout_i),
    .timeout_o      (timeout_o),
    .overrun_o      (overrun_o),
    .overrun_clr_i  (overrun_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d);
    checkOutput("ready_before_push", 32'(in_if.ready), 32'd1);
    in_if.valid = 1'b1;
    in_if.data  = d;
    tick();
    in_if.valid = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic drain(input int n);
    out_if.ready = 1'b1;
    repeat (n) tick();
    out_if.ready = 1'b0;
  endtask

  // Pops are decided by the levels seen mid-cycle, ahead of the edge that performs them.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && !clr_i && out_if.valid && out_if.ready) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no data", out_if.data);
        end else begin
          checkOutput("pop_data", 32'(out_if.data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;

    // 1: reset state
    #23 rst_i = 1'b0;
    tick();
    checkOutput("rst_ready", 32'(in_if.ready), 32'd1);
    checkOutput("rst_valid", 32'(out_if.valid), 32'd0);
    checkOutput("rst_elements", 32'(elements_o), 32'd0);
    checkOutput("rst_empty", 32'(empty_o), 32'd1);
    checkOutput("rst_full", 32'(full_o), 32'd0);
    checkOutput("rst_trig", 32'(trig_o), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_o), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_o), 32'd0);

    // 2: fill to full then drain in order
    for (int i = 0; i < 16; i++) applyStimulus(8'(i));
    checkOutput("fill_elements", 32'(elements_o), 32'd16);
    checkOutput("fill_full", 32'(full_o), 32'd1);
    checkOutput("fill_ready", 32'(in_if.ready), 32'd0);
    drain(16);
    checkOutput("drain_empty", 32'(empty_o), 32'd1);
    checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);

    // 3: overrun set, clear, and clear-wins
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h20 + i));
    in_if.valid = 1'b1;
    in_if.data  = 8'hA5;
    tick();
    in_if.valid = 1'b0;
    checkOutput("ovr_set", 32'(overrun_o), 32'd1);
    checkOutput("ovr_elements", 32'(elements_o), 32'd16);
    overrun_clr_i = 1'b1;
    tick();
    overrun_clr_i = 1'b0;
    checkOutput("ovr_clear", 32'(overrun_o), 32'd0);
    in_if.valid = 1'b1;
    overrun_clr_i = 1'b1;
    tick();
    in_if.valid = 1'b0;
    overrun_clr_i = 1'b0;
    checkOutput("ovr_clr_wins", 32'(overrun_o), 32'd0);
    drain(16);
    checkOutput("ovr_drain_empty", 32'(empty_o), 32'd1);

    // 4: steady level 5 with simultaneous push/pop across the wrap
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h30 + i));
    out_if.ready = 1'b1;
    in_if.valid  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_if.data = 8'(8'h40 + i);
      exp_q.push_back(8'(8'h40 + i));
      tick();
      checkOutput("level5_elements", 32'(elements_o), 32'd5);
    end
    in_if.valid = 1'b0;
    repeat (5) tick();
    out_if.ready = 1'b0;
    checkOutput("level5_empty", 32'(empty_o), 32'd1);
    checkOutput("latency_before", 32'(out_if.valid), 32'd0);
    applyStimulus(8'h99);
    checkOutput("latency_after", 32'(out_if.valid), 32'd1);
    drain(1);

    // 5: trigger level
    cfg_trig_lvl_i = 5'd4;
    for (int i = 0; i < 3; i++) applyStimulus(8'(8'h50 + i));
    checkOutput("trig_below", 32'(trig_o), 32'd0);
    applyStimulus(8'h53);
    checkOutput("trig_at_level", 32'(trig_o), 32'd1);
    drain(1);
    checkOutput("trig_after_pop", 32'(trig_o), 32'd0);
    cfg_trig_lvl_i = 5'd0;
    for (int i = 0; i < 13; i++) applyStimulus(8'(8'h60 + i));
    checkOutput("trig_disabled_full", 32'(trig_o), 32'd0);
    cfg_trig_lvl_i = 5'd17;
    #1 checkOutput("trig_above_depth", 32'(trig_o), 32'd0);
    cfg_trig_lvl_i = 5'd16;
    #1 checkOutput("trig_eq_depth", 32'(trig_o), 32'd1);
    cfg_trig_lvl_i = 5'd0;
    drain(16);
    checkOutput("trig_drain_empty", 32'(empty_o), 32'd1);

    // 6: character timeout and flush
    cfg_timeout_i = 16'd10;
    applyStimulus(8'h77);
    for (int k = 1; k <= 12; k++) begin
      tick();
      checkOutput($sformatf("timeout_cycle%0d", k), 32'(timeout_o), (k >= 10) ? 32'd1 : 32'd0);
    end
    drain(1);
    checkOutput("timeout_after_pop", 32'(timeout_o), 32'd0);
    for (int i = 0; i < 7; i++) applyStimulus(8'(8'h80 + i));
    repeat (12) tick();
    checkOutput("timeout_seven", 32'(timeout_o), 32'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    exp_q.delete();
    checkOutput("clr_elements", 32'(elements_o), 32'd0);
    checkOutput("clr_timeout", 32'(timeout_o), 32'd0);
    checkOutput("clr_overrun", 32'(overrun_o), 32'd0);
    checkOutput("clr_empty", 32'(empty_o), 32'd1);

    // Flush beats a simultaneous overrun and push
    for (int i = 0; i < 16; i++) applyStimulus(8'(8'h90 + i));
    in_if.valid = 1'b1;
    in_if.data  = 8'hEE;
    tick();
    checkOutput("ovr_before_clr", 32'(overrun_o), 32'd1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    in_if.valid = 1'b0;
    exp_q.delete();
    checkOutput("clr_ovr_cleared", 32'(overrun_o), 32'd0);
    checkOutput("clr_push_ignored", 32'(elements_o), 32'd0);

    applyStimulus(8'h3C);
    drain(1);
    checkOutput("final_queue", 32'(exp_q.size()), 32'd0);
    checkOutput("final_empty", 32'(empty_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. Accepts each received character over a valid/ready handshake, stores up to DEPTH characters and presents them first-word-fall-through to the APB register read path. Generates the level-trigger and character-timeout interrupt sources and a sticky overrun flag. Prevents the receiver from stalling in its save state while software is slow to read.

Parameters:
DATA_WIDTH, 8, width of one stored character
DEPTH, 16, number of entries; power of two, >= 2
LOG_DEPTH, $clog2(DEPTH), derived; not to be overridden

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  asynchronous active-high reset
clr_i  input  1  synchronous flush (FIFO reset bit in control register)
data_i  input  DATA_WIDTH  character from receiver
valid_i  input  1  receiver offers data_i
ready_o  output  1  FIFO accepts data_i (= !full_o)
data_o  output  DATA_WIDTH  oldest stored character
valid_o  output  1  data_o valid (= !empty_o)
ready_i  input  1  consumer (register read) takes data_o
elements_o  output  LOG_DEPTH+1  current fill level, 0..DEPTH
full_o  output  1  elements_o == DEPTH
empty_o  output  1  elements_o == 0
cfg_trig_lvl_i  input  LOG_DEPTH+1  interrupt trigger level; 0 disables
trig_o  output  1  level interrupt source
cfg_timeout_i  input  16  idle cycles before timeout; 0 disables
timeout_o  output  1  character-timeout interrupt source
overrun_o  output  1  sticky: character offered while full
overrun_clr_i  input  1  clears overrun_o

Behaviour:
- Reset (rst_i high, async): wr_ptr=rd_ptr=0, count=0, idle counter=0, overrun_o=0; hence ready_o=1, valid_o=0, empty_o=1, full_o=0, elements_o=0, trig_o=0, timeout_o=0. Storage array is not reset; data_o undefined while empty.
- push = valid_i & ready_o; pop = valid_o & ready_i. Both evaluated on the same edge.
- Push writes mem[wr_ptr], wr_ptr+1 modulo DEPTH (natural wrap, LOG_DEPTH bits). Pop advances rd_ptr+1 modulo DEPTH.
- count: +1 push only, -1 pop only, unchanged on both or neither. Never exceeds DEPTH or underflows by construction.
- Full: ready_o=0 even if pop occurs same cycle (no pass-through on full). Empty: no bypass; a pushed character appears on data_o/valid_o one cycle after the push edge (latency 1).
- data_o = mem[rd_ptr] combinationally; stable while valid_o=1 and no pop.
- clr_i: on the edge, pointers, count, idle counter and overrun_o go to 0; push and pop in that cycle are ignored. clr_i has priority over all other updates except rst_i.
- trig_o = (cfg_trig_lvl_i != 0) && (elements_o >= cfg_trig_lvl_i); combinational from registered count; cfg_trig_lvl_i > DEPTH means never.
- Idle counter (16 bit): cleared on any push, pop, or when empty; otherwise +1 per cycle, saturating at 0xFFFF.
- timeout_o = (cfg_timeout_i != 0) && !empty_o && (idle_cnt >= cfg_timeout_i); thus rises exactly cfg_timeout_i cycles after the last push/pop edge; drops the cycle after a pop or flush.
- overrun_o: set on edge when valid_i && full_o && !clr_i; offered character discarded. overrun_clr_i wins over a simultaneous set. Holds until cleared, flushed or reset.
- rst_i asserted mid-transfer: immediate return to reset state; no partial write survives in count.

Test Plan:
1. Apply rst_i, release -> ready_o=1, valid_o=0, elements_o=0, trig_o=0, timeout_o=0, overrun_o=0.
2. ready_i=0, push 0x00..0x0F -> elements_o=16, full_o=1, ready_o=0; then ready_i=1 -> data_o reads 0x00..0x0F in order, empty_o=1 after 16 pops.
3. Full FIFO, hold valid_i=1 with 0xA5 -> overrun_o=1 next cycle, elements_o stays 16, 0xA5 never read; overrun_clr_i pulse -> overrun_o=0; set and clear in same cycle -> stays 0.
4. Level 5, push and pop every cycle for 40 cycles (incrementing data) -> elements_o stays 5, order preserved across pointer wrap; push into empty -> valid_o high exactly one cycle later.
5. cfg_trig_lvl_i=4: push 4 bytes -> trig_o high after 4th push edge, low after next pop; cfg_trig_lvl_i=0 -> trig_o never high.
6. cfg_timeout_i=10: push one byte, idle -> timeout_o rises exactly 10 cycles after push edge; pop -> low next cycle; clr_i with 7 entries -> elements_o=0, timeout_o=0, overrun_o=0 in one cycle.
